// File: rtl/adiabatic_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adiabatic_alu_pkg
// Purpose  : Shared types and operation decode for the adiabatic ALU
// Revision : 1.0 - initial release
// ============================================================================
package adiabatic_alu_pkg;

   // Operation select encoding as seen on the request bus
   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_SBB = 2'b10,
      OP_INC = 2'b11
   } op_e;

   // Sequencer states, explicitly encoded
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHARGE = 2'd1,
      ST_HOLD   = 2'd2,
      ST_DRAIN  = 2'd3
   } state_e;

   // Width-independent operand controls: how to form b_eff and the carry in
   typedef struct packed {
      logic inv_b;
      logic zero_b;
      logic carry;
   } op_ctl_t;

   // Map an operation onto b_eff selection and carry into the adder
   function automatic op_ctl_t op_decode(input op_e op, input logic cin);
      op_ctl_t ctl;
      ctl = '0;
      case (op)
         OP_ADD: begin ctl.inv_b = 1'b0; ctl.zero_b = 1'b0; ctl.carry = cin;  end
         OP_SUB: begin ctl.inv_b = 1'b1; ctl.zero_b = 1'b0; ctl.carry = 1'b1; end
         OP_SBB: begin ctl.inv_b = 1'b1; ctl.zero_b = 1'b0; ctl.carry = cin;  end
         default: begin ctl.inv_b = 1'b0; ctl.zero_b = 1'b1; ctl.carry = 1'b1; end
      endcase
      return ctl;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adiabatic_alu_b_if.sv
`default_nettype none
// ============================================================================
// Module   : adiabatic_alu_b_if
// Purpose  : Request/result handshake, status and clock-rail bundle
// Revision : 1.0 - initial release
// ============================================================================
interface adiabatic_alu_b_if #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              cin;
   logic [1:0]        op;
   logic              res_valid;
   logic              res_ready;
   logic [WIDTH-1:0]  out;
   logic              cout;
   logic              ovf;
   logic              zero;
   logic              busy;
   logic [STAGES-1:0] clkp_out;
   logic [STAGES-1:0] clkn_out;
   logic [WIDTH-1:0]  propagate;
   logic [WIDTH-1:0]  generate_;

   modport master (
      output req_valid, a, b, cin, op, res_ready,
      input  req_ready, res_valid, out, cout, ovf, zero, busy,
             clkp_out, clkn_out, propagate, generate_
   );

   modport slave (
      input  req_valid, a, b, cin, op, res_ready,
      output req_ready, res_valid, out, cout, ovf, zero, busy,
             clkp_out, clkn_out, propagate, generate_
   );
endinterface
`default_nettype wire

// File: rtl/bennett_seq.sv
`default_nettype none
// ============================================================================
// Module   : bennett_seq
// Purpose  : Bennett clock rail sequencer. Each charge step raises the next
//            rail upward from 0; each drain step lowers the top raised rail.
// Revision : 1.0 - initial release
// ============================================================================
module bennett_seq #(
   parameter int STAGES = 8
) (
   input  wire logic              clk,
   input  wire logic              reset,          // asynchronous, active-low
   input  wire logic              i_charge_en,
   input  wire logic              i_drain_en,
   output logic [STAGES-1:0]      o_clkp,
   output logic [STAGES-1:0]      o_clkn,
   output logic                   o_charge_last,  // this charge step raises the top rail
   output logic                   o_drain_last    // this drain step lowers rail 0
);
   localparam int               C_IDX_W    = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(STAGES - 1);

   logic [C_IDX_W-1:0] idx_q, idx_d;
   logic [STAGES-1:0]  clkp_q, clkp_d;

   // Step the rail pointer: it parks on the top rail after charging so the
   // drain walks back down without any reload
   always_comb begin
      idx_d  = idx_q;
      clkp_d = clkp_q;
      if (i_charge_en) begin
         clkp_d[idx_q] = 1'b1;
         if (idx_q != C_LAST_IDX) idx_d = idx_q + C_IDX_W'(1);
      end else if (i_drain_en) begin
         clkp_d[idx_q] = 1'b0;
         if (idx_q != '0) idx_d = idx_q - C_IDX_W'(1);
      end
   end

   // Rail and pointer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q  <= '0;
         clkp_q <= '0;
      end else begin
         idx_q  <= idx_d;
         clkp_q <= clkp_d;
      end
   end

   assign o_clkp        = clkp_q;
   assign o_clkn        = ~clkp_q;
   assign o_charge_last = (idx_q == C_LAST_IDX);
   assign o_drain_last  = (idx_q == '0);

endmodule
`default_nettype wire

// File: rtl/adiabatic_alu_b.sv
`default_nettype none
// ============================================================================
// Module   : adiabatic_alu_b
// Purpose  : WIDTH-bit add/sub ALU evaluated under a sequenced Bennett clock
//            with valid/ready request and result handshakes
// Revision : 1.0 - initial release
// ============================================================================
module adiabatic_alu_b
   import adiabatic_alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 8,
   parameter int HOLD   = 1
) (
   input  wire logic          clk,
   input  wire logic          reset,   // asynchronous, active-low
   adiabatic_alu_b_if.slave   bus
);
   localparam int                C_HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [C_HC_W-1:0] C_HOLD_LAST = C_HC_W'(HOLD - 1);

   state_e             state_q, state_d;
   logic [C_HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_eff_q, b_eff_d;
   logic               carry_q, carry_d;
   logic               res_valid_q, res_valid_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;

   op_ctl_t            w_ctl;
   logic [WIDTH-1:0]   w_b_eff;
   logic [WIDTH:0]     w_sum;
   logic               w_hold_done;
   logic               w_capture;
   logic               w_accept;
   logic               w_charge_en;
   logic               w_drain_en;
   logic               w_charge_last;
   logic               w_drain_last;
   logic               w_req_ready;
   logic               w_busy;

   // Rail sequencer
   bennett_seq #(.STAGES(STAGES)) u_seq (
      .clk          (clk),
      .reset        (reset),
      .i_charge_en  (w_charge_en),
      .i_drain_en   (w_drain_en),
      .o_clkp       (bus.clkp_out),
      .o_clkn       (bus.clkn_out),
      .o_charge_last(w_charge_last),
      .o_drain_last (w_drain_last)
   );

   // Operand shaping, adder on latched operands and capture qualification
   always_comb begin
      w_ctl       = op_decode(op_e'(bus.op), bus.cin);
      w_b_eff     = w_ctl.zero_b ? '0 : (w_ctl.inv_b ? ~bus.b : bus.b);
      w_sum       = {1'b0, a_q} + {1'b0, b_eff_q} + {{WIDTH{1'b0}}, carry_q};
      w_hold_done = (hold_cnt_q == C_HOLD_LAST);
      // A full result register only blocks capture if the consumer is not
      // draining it in this same cycle
      w_capture   = (state_q == ST_HOLD) && w_hold_done &&
                    (!res_valid_q || bus.res_ready);
      w_accept    = (state_q == ST_IDLE) && bus.req_valid;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.req_valid) state_d = ST_CHARGE;
         ST_CHARGE: if (w_charge_last) state_d = ST_HOLD;
         ST_HOLD:   if (w_capture)     state_d = ST_DRAIN;
         ST_DRAIN:  if (w_drain_last)  state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   // State-decoded controls; all derive from the registered state only
   always_comb begin
      w_charge_en = (state_q == ST_CHARGE);
      w_drain_en  = (state_q == ST_DRAIN);
      w_req_ready = (state_q == ST_IDLE);
      w_busy      = (state_q != ST_IDLE);
   end

   // Hold timer, operand latches and result register next values
   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      a_d         = a_q;
      b_eff_d     = b_eff_q;
      carry_d     = carry_q;
      res_valid_d = res_valid_q;
      out_d       = out_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;

      // Counter saturates at the last hold cycle so a stall just waits there
      if (state_q != ST_HOLD)  hold_cnt_d = '0;
      else if (!w_hold_done)   hold_cnt_d = hold_cnt_q + C_HC_W'(1);

      if (w_accept) begin
         a_d     = bus.a;
         b_eff_d = w_b_eff;
         carry_d = w_ctl.carry;
      end

      if (w_capture) begin
         res_valid_d = 1'b1;
         out_d       = w_sum[WIDTH-1:0];
         cout_d      = w_sum[WIDTH];
         ovf_d       = (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != a_q[WIDTH-1]);
         zero_d      = (w_sum[WIDTH-1:0] == '0);
      end else if (bus.res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   // Control and data registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         hold_cnt_q  <= '0;
         a_q         <= '0;
         b_eff_q     <= '0;
         carry_q     <= 1'b0;
         res_valid_q <= 1'b0;
         out_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         a_q         <= a_d;
         b_eff_q     <= b_eff_d;
         carry_q     <= carry_d;
         res_valid_q <= res_valid_d;
         out_q       <= out_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.busy      = w_busy;
   assign bus.res_valid = res_valid_q;
   assign bus.out       = out_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.propagate = a_q ^ b_eff_q;
   assign bus.generate_ = a_q & b_eff_q;

endmodule
`default_nettype wire

// File: doc/adiabatic_alu_b.md
# adiabatic_alu_b

Parametrised successor of the 16-bit Bennett-clocked adder wrapper. Performs WIDTH-bit add/subtract operations through an internally sequenced Bennett clock: charge STAGES phases, hold, capture, then drain in reverse. Adds a valid/ready request and result handshake, an operation select and status flags. Sits between the ALU test harness and the adiabatic datapath; the clock rails are exported for monitoring.

## Interface
- WIDTH, 16, operand and result width (≥2)
- STAGES, 8, Bennett clock phase count (≥1)
- HOLD, 1, cycles all phases stay high before capture (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (ADD, SBB only)
- op  in  2  00 ADD, 01 SUB, 10 SBB, 11 INC
- res_valid  out  1  result register full
- res_ready  in  1  consumer takes result
- out  out  WIDTH  result
- cout  out  1  carry out (SUB/SBB: 1 = no borrow)
- ovf  out  1  signed overflow
- zero  out  1  out == 0
- busy  out  1  state != IDLE
- clkp_out  out  STAGES  Bennett positive rails
- clkn_out  out  STAGES  always ~clkp_out
- propagate  out  WIDTH  a ^ b_eff of latched operands
- generate_  out  WIDTH  a & b_eff of latched operands

## Operation
- Effective operation: ADD a+b+cin; SUB a+~b+1; SBB a+~b+cin; INC a+0+1. b_eff = b, ~b, ~b, 0 respectively.
- cout = bit WIDTH of the (WIDTH+1)-bit sum; ovf = (a[MSB]==b_eff[MSB]) && (out[MSB]!=a[MSB]).
- FSM: IDLE → CHARGE → HOLD → DRAIN → IDLE.
- IDLE: req_ready=1. On req_valid: latch a, b_eff, carry, op; go CHARGE, idx=0.
- CHARGE: each cycle set clkp[idx], idx++; after clkp[STAGES-1] set go HOLD.
- HOLD: count HOLD cycles; on last, capture out/cout/ovf/zero if result register empty or res_ready this cycle; else stay in HOLD (all rails high) until free.
- DRAIN: clear clkp from STAGES-1 down to 0, one per cycle; clearing clkp[0] returns to IDLE.
- Result register: res_valid set on capture, cleared on res_ready && !capture; capture and consume in same cycle leaves res_valid=1 with new data.
- Reset (any time, incl. mid-CHARGE/DRAIN): state IDLE, all clkp 0, clkn all 1, res_valid 0, out/cout/ovf 0, zero 1, propagate/generate_ 0, req_ready 1 after release.

## Timing
- Accept at edge E0. clkp[k] rises at E(k+1); all high at E(STAGES).
- Capture at E(STAGES+HOLD) when unstalled: res_valid high from that edge (8/1 defaults: 9 cycles).
- clkp[STAGES-1-j] falls at E(STAGES+HOLD+1+j); IDLE at E(2·STAGES+HOLD); next accept earliest at that edge's following cycle.
- Stall of s cycles in HOLD delays capture and drain by s.
- req_ready, busy, flags are registered-state decodes; no combinational path req_valid→req_ready.

## Structure
- Package adiabatic_alu_pkg: op_e enum (ADD, SUB, SBB, INC), state_e enum, op decode function returning b_eff/carry.
- Sub-module bennett_seq #(STAGES): start/drain commands in, clkp/clkn out, charged/drained status; top holds FSM, operand latches, result register.

## Test plan
- ADD a=16'h1234 b=16'h0001 cin=0 → out 16'h1235, cout 0, ovf 0, res_valid at E9.
- SUB a=0 b=1 → out 16'hFFFF, cout 0, ovf 0, zero 0; SUB a=b=16'h5A5A → out 0, zero 1, cout 1.
- ADD 16'h7FFF+16'h0001 → 16'h8000, ovf 1; INC 16'hFFFF → 0, cout 1, zero 1.
- res_ready held low, second request issued → second op stalls in HOLD with clkp_out=8'hFF until res_ready pulse, then captures next cycle.
- reset asserted when clkp_out=8'h07 → clkp_out 0, clkn_out 8'hFF, res_valid 0, req_ready 1 after release.
- WIDTH=8 STAGES=4 HOLD=2: ADD 8'hF0+8'h20 → 8'h10, cout 1, res_valid at E6, IDLE at E10.
